// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: mode codes, FSM states,
// the arctangent table at rad*2^29, pi constants, and fixed-point helpers.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Angle table scale and size; the iteration index is wide enough for every entry.
    localparam int ANGLE_FRAC   = 29;
    localparam int ATAN_ENTRIES = 24;
    localparam int ITER_IDX_W   = 5;

    // atan(2^-i) * 2^29, rounded to nearest, i = 0..23
    localparam logic signed [31:0] ATAN_TABLE [ATAN_ENTRIES] = '{
        32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
        32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
        32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
        32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384,
        32'sd8192,      32'sd4096,      32'sd2048,      32'sd1024,
        32'sd512,       32'sd256,       32'sd128,       32'sd64
    };

    localparam logic signed [31:0] PI_ANGLE      = 32'sd1686629713;
    localparam logic signed [31:0] HALF_PI_ANGLE = 32'sd843314857;

    // Rescale a rad*2^29 angle down by 'shift' bits with round-half-up.
    function automatic logic signed [31:0] round_angle(input logic signed [31:0] a,
                                                       input int shift);
        return (a + (32'sd1 <<< (shift - 1))) >>> shift;
    endfunction

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                        input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: returns atan(2^-idx) in the engine's
// internal angle format (rad*2^(WIDTH-3)), sign-extended to WIDTH+GUARD bits.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GUARD = 2
) (
    input  logic [ITER_IDX_W-1:0]         idx,
    output logic signed [WIDTH+GUARD-1:0] angle
);
    localparam int IW    = WIDTH + GUARD;
    localparam int SHIFT = ANGLE_FRAC - (WIDTH - 3);

    logic signed [31:0] entry;

    // Table lookup with rounding to the narrower angle scale; indices past the table read zero.
    always_comb begin
        entry = 32'sd0;
        if (idx < ITER_IDX_W'(ATAN_ENTRIES)) begin
            entry = ATAN_TABLE[idx];
        end
        angle = IW'(round_angle(entry, SHIFT));
    end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine with valid/ready handshakes. One micro-rotation per
// clock; full-circle coverage via quadrant pre-rotation at capture; results
// saturated to WIDTH bits and held until the sink takes them.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = 14,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] res1,
    output logic signed [WIDTH-1:0] res2
);
    localparam int IW    = WIDTH + GUARD;
    localparam int SHIFT = ANGLE_FRAC - (WIDTH - 3);

    localparam logic signed [IW-1:0] PI_Z      = IW'(round_angle(PI_ANGLE, SHIFT));
    localparam logic signed [IW-1:0] HALF_PI_Z = IW'(round_angle(HALF_PI_ANGLE, SHIFT));
    localparam logic [ITER_IDX_W-1:0] LAST_ITER = ITER_IDX_W'(ITERS - 1);

    state_t                  state;
    logic [ITER_IDX_W-1:0]   iter;
    logic                    mode_r;
    logic                    accept;

    logic signed [IW-1:0]    x_cur, y_cur, z_cur;
    logic signed [IW-1:0]    x_ext, y_ext, z_ext;
    logic signed [IW-1:0]    x_pre, y_pre, z_pre;
    logic signed [IW-1:0]    x_nxt, y_nxt, z_nxt;
    logic signed [IW-1:0]    x_sh, y_sh;
    logic signed [IW-1:0]    atan_step;
    logic                    dir_pos;

    // Clamp the wide internal value to the output word.
    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [IW-1:0] v);
        return WIDTH'(sat_to_width(32'(v), WIDTH));
    endfunction

    assign accept = in_valid && in_ready;

    cordic_atan_rom #(
        .WIDTH (WIDTH),
        .GUARD (GUARD)
    ) u_atan_rom (
        .idx   (iter),
        .angle (atan_step)
    );

    // Capture-cycle quadrant fold so the micro-rotations only need to cover +/-pi/2.
    always_comb begin
        x_ext = IW'(x_in);
        y_ext = IW'(y_in);
        z_ext = IW'(z_in);
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = z_ext;
        if (mode == MODE_ROT) begin
            if (z_ext > HALF_PI_Z) begin
                x_pre = -x_ext;
                y_pre = -y_ext;
                z_pre = z_ext - PI_Z;
            end else if (z_ext < -HALF_PI_Z) begin
                x_pre = -x_ext;
                y_pre = -y_ext;
                z_pre = z_ext + PI_Z;
            end
        end else begin
            z_pre = '0;
            if (x_ext < 0) begin
                x_pre = -x_ext;
                y_pre = -y_ext;
                z_pre = (y_ext >= 0) ? PI_Z : -PI_Z;
            end
        end
    end

    // One micro-rotation: direction from the sign of z (rotation) or y (vectoring).
    always_comb begin
        dir_pos = (mode_r == MODE_ROT) ? !z_cur[IW-1] : y_cur[IW-1];
        x_sh    = x_cur >>> iter;
        y_sh    = y_cur >>> iter;
        if (dir_pos) begin
            x_nxt = x_cur - y_sh;
            y_nxt = y_cur + x_sh;
            z_nxt = z_cur - atan_step;
        end else begin
            x_nxt = x_cur + y_sh;
            y_nxt = y_cur - x_sh;
            z_nxt = z_cur + atan_step;
        end
    end

    // Working registers: load the folded inputs on accept, then iterate while running.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_r <= mode;
            x_cur  <= x_pre;
            y_cur  <= y_pre;
            z_cur  <= z_pre;
        end else if (state == RUN) begin
            x_cur  <= x_nxt;
            y_cur  <= y_nxt;
            z_cur  <= z_nxt;
        end
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res1      <= '0;
            res2      <= '0;
            iter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        in_ready <= 1'b0;
                        iter     <= '0;
                    end
                end
                RUN: begin
                    if (iter == LAST_ITER) begin
                        state <= DONE;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        res1      <= clamp(x_cur);
                        res2      <= (mode_r == MODE_VEC) ? clamp(z_cur) : clamp(y_cur);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter at WIDTH=16, ITERS=14 (1.0 = 8192).
module tb_cordic_iter;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic signed [15:0] z_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] res1;
    logic signed [15:0] res2;

    int checks = 0;
    int errors = 0;
    int lat;

    cordic_iter #(
        .WIDTH (16),
        .ITERS (14),
        .GUARD (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res1      (res1),
        .res2      (res2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp, input int tol);
        checks++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Present one transaction for a single accept edge, then scramble the inputs.
    task automatic send(input string tag, input logic m, input int xv, input int yv,
                        input int zv);
        @(negedge clk);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        mode     = m;
        x_in     = 16'(xv);
        y_in     = 16'(yv);
        z_in     = 16'(zv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = ~m;
        x_in     = 16'sh5a5a;
        y_in     = -16'sh1234;
        z_in     = 16'sh3c3c;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_valid !== 1'b1 && n < 40);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_res1", res1, 0);
        check_eq("rst_res2", res2, 0);
        reset = 1'b0;

        // 1. Rotation by pi/4 of (1/K, 0), with latency
        send("s1", 1'b0, 4975, 0, 6434);
        wait_result(lat);
        check_eq("s1_latency", lat, 15);
        check_near("s1_res1", res1, 5793, 4);
        check_near("s1_res2", res2, 5793, 4);
        consume("s1");

        // 2. Vectoring (1,1)
        send("s2", 1'b1, 8192, 8192, 0);
        wait_result(lat);
        check_eq("s2_valid", out_valid, 1);
        check_near("s2_res1", res1, 19079, 4);
        check_near("s2_res2", res2, 6434, 4);
        consume("s2");

        // 3a. Rotation by pi
        send("s3a", 1'b0, 4975, 0, 25736);
        wait_result(lat);
        check_eq("s3a_valid", out_valid, 1);
        check_near("s3a_res1", res1, -8192, 4);
        check_near("s3a_res2", res2, 0, 4);
        consume("s3a");

        // 3b. Vectoring on the negative x axis, y = 0
        send("s3b", 1'b1, -8192, 0, 0);
        wait_result(lat);
        check_eq("s3b_valid", out_valid, 1);
        check_near("s3b_res1", res1, 13491, 4);
        check_near("s3b_res2", res2, 25736, 4);
        consume("s3b");

        // 3c. Vectoring just below the negative x axis
        send("s3c", 1'b1, -8192, -1, 0);
        wait_result(lat);
        check_eq("s3c_valid", out_valid, 1);
        check_near("s3c_res2", res2, -25736, 4);
        consume("s3c");

        // 4. Backpressure, with a competing input request held high
        send("s4", 1'b1, 8192, 8192, 0);
        wait_result(lat);
        check_eq("s4_latency", lat, 15);
        @(negedge clk);
        mode     = 1'b0;
        x_in     = 16'sd4975;
        y_in     = 16'sd0;
        z_in     = 16'sd6434;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq("s4_hold_valid", out_valid, 1);
            check_eq("s4_hold_in_ready", in_ready, 0);
            check_near("s4_hold_res1", res1, 19079, 4);
            check_near("s4_hold_res2", res2, 6434, 4);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("s4_release_valid", out_valid, 0);
        check_eq("s4_release_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("s4_no_accept_on_drain", in_ready, 1);

        // 5. Reset during iteration 6, then a clean transaction
        send("s5", 1'b0, 4975, 0, 6434);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("s5_rst_in_ready", in_ready, 1);
        check_eq("s5_rst_out_valid", out_valid, 0);
        check_eq("s5_rst_res1", res1, 0);
        check_eq("s5_rst_res2", res2, 0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("s5_no_partial_result", out_valid, 0);
        send("s5b", 1'b0, 4975, 0, 6434);
        wait_result(lat);
        check_eq("s5b_latency", lat, 15);
        check_near("s5b_res1", res1, 5793, 4);
        check_near("s5b_res2", res2, 5793, 4);
        consume("s5b");

        // 6. Magnitude saturation
        send("s6", 1'b1, 32767, 32767, 0);
        wait_result(lat);
        check_eq("s6_valid", out_valid, 1);
        check_eq("s6_res1_clamped", res1, 32767);
        check_near("s6_res2", res2, 6434, 4);
        consume("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
